mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port A: CPU load/store path, i.e. the address and write-data leaving the memory/IO select logic.
  - port B: UART program loader / debug DMA.
- Sequences each access through a small FSM with req/ack handshakes and registered memory control. Round-robin between A and B.
- Sits between both requesters and the data-memory block RAM (synchronous read, 1-cycle latency).

Parameters:
- ADDR_WIDTH, 14, word-address width to data memory.
- DATA_WIDTH, 32, data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  port A request; held high with addr/we/wdata stable until ack_a.
- we_a  input  1  port A write enable (1 = write, 0 = read).
- addr_a  input  ADDR_WIDTH  port A word address.
- wdata_a  input  DATA_WIDTH  port A write data.
- ack_a  output  1  one-cycle completion pulse to A.
- rdata_a  output  DATA_WIDTH  port A read data, valid while ack_a=1, held afterwards.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as port A, for port B.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after a read issue.
- busy  output  1  high in any state except IDLE.
- gnt_b  output  1  current or last grant owner (1 = B).

Behaviour:
- All outputs are registered.
- Reset values:
  - ack_a, ack_b, mem_en, mem_we, busy, gnt_b = 0.
  - mem_addr, mem_wdata, rdata_a, rdata_b = 0.
  - state = IDLE; round-robin pointer last = B, so A wins the first tie.
- States: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - Only one requesting: grant it.
  - Both requesting: grant the port that is not `last`, then set last to the granted port.
  - On grant: register the granted addr/we/wdata into mem_addr/mem_we/mem_wdata; mem_en<=1; gnt_b<=granted; busy<=1; next state ISSUE.
  - No request: stay in IDLE, mem_en=0.
- ISSUE: mem_en=1 for exactly this cycle.
  - Write: next RESP.
  - Read: next CAPT.
  - mem_en and mem_we drop to 0 on leaving ISSUE.
- CAPT: latch mem_rdata into rdata of the granted port; next RESP.
- RESP: ack of the granted port = 1 for exactly this cycle; next IDLE; busy drops on entry to IDLE.
- Latency, with request sampled in IDLE at cycle T:
  - write: ack in cycle T+2.
  - read: ack in cycle T+3.
  - New request possible in cycle T+3 (write) or T+4 (read), since one IDLE cycle separates transactions.
- Requester rules:
  - Requester drops req in the cycle after ack.
  - A req still high in the IDLE cycle after its own ack is treated as a new request.
- Request inputs are ignored outside IDLE. Changes to addr/we/wdata after grant have no effect, because the values are latched in IDLE.
- A req withdrawn after grant: the transaction still completes and still acks.
- The non-granted port waits, with its ack held at 0, until arbitration in the next IDLE.
- ack_a and ack_b are never high in the same cycle.
- Reset mid-transaction: the transaction is abandoned and no ack is issued; mem_en drops at the reset edge.
- The arbiter does no address decode. IO decoding stays downstream on port A's path.

Optional Feature:
- Macro: ARB_B_PRIORITY_EN.
- Defined:
  - Port B always wins when both request; round-robin pointer unused.
  - Intended for UART download while the CPU is halted.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then single A write (addr 0x0010, data 0xDEADBEEF) -> mem_en=1, mem_we=1, mem_addr=0x0010 in T+1; ack_a in T+2; ack_b stays 0.
- A read of 0x0010 after the write -> ack_a in T+3 with rdata_a=0xDEADBEEF; rdata_a holds that value after ack.
- A and B both request writes in the same IDLE after reset -> A served first, B acked 3 cycles after ack_a. Repeat a simultaneous request -> B served first, since round-robin has flipped.
- B issues reads back-to-back while A is held high -> A and B alternate; neither is starved for more than one transaction.
- Assert rst during CAPT of a B read -> no ack_b; all outputs 0 on the next cycle; the next A request is granted normally.
- With ARB_B_PRIORITY_EN defined, two simultaneous requests from both ports -> B is granted both times.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: both requester handshakes plus the data-memory port.
// slave = arbiter view, master = requesters and RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  req_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  ack_a;
  logic [DATA_WIDTH-1:0] rdata_a;

  logic                  req_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  ack_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  gnt_b;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_rdata,
    output ack_a, rdata_a, ack_b, rdata_b,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, gnt_b
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_rdata,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, gnt_b
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port data RAM (CPU port A, loader/DMA port B), round-robin.
// Optional macro ARB_B_PRIORITY_EN: port B always wins a simultaneous request.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_n;

  logic                  r_ack_a;
  logic                  r_ack_b;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;
  logic                  r_busy;
  logic                  r_gnt_b;

  logic                  w_ack_a_n;
  logic                  w_ack_b_n;
  logic                  w_mem_en_n;
  logic                  w_mem_we_n;
  logic [ADDR_WIDTH-1:0] w_mem_addr_n;
  logic [DATA_WIDTH-1:0] w_mem_wdata_n;
  logic [DATA_WIDTH-1:0] w_rdata_a_n;
  logic [DATA_WIDTH-1:0] w_rdata_b_n;
  logic                  w_busy_n;
  logic                  w_gnt_b_n;

  logic                  w_any_req;
  logic                  w_grant_b;

  assign w_any_req = bus.req_a || bus.req_b;

`ifdef ARB_B_PRIORITY_EN
  assign w_grant_b = bus.req_b;
`else
  logic r_last_b;
  logic w_tie;

  assign w_tie     = bus.req_a && bus.req_b;
  // On a tie the port that did not win the previous tie gets the grant.
  assign w_grant_b = w_tie ? !r_last_b : bus.req_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (r_state == IDLE && w_tie) begin
      r_last_b <= w_grant_b;
    end
  end
`endif

  always_comb begin
    w_state_n     = r_state;
    w_ack_a_n     = 1'b0;
    w_ack_b_n     = 1'b0;
    w_mem_en_n    = 1'b0;
    w_mem_we_n    = 1'b0;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_rdata_a_n   = r_rdata_a;
    w_rdata_b_n   = r_rdata_b;
    w_busy_n      = r_busy;
    w_gnt_b_n     = r_gnt_b;

    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_n     = ISSUE;
          w_mem_en_n    = 1'b1;
          w_mem_we_n    = w_grant_b ? bus.we_b    : bus.we_a;
          w_mem_addr_n  = w_grant_b ? bus.addr_b  : bus.addr_a;
          w_mem_wdata_n = w_grant_b ? bus.wdata_b : bus.wdata_a;
          w_gnt_b_n     = w_grant_b;
          w_busy_n      = 1'b1;
        end
      end
      ISSUE: begin
        // Writes skip CAPT, so their ack is raised on the way into RESP here.
        if (r_mem_we) begin
          w_state_n = RESP;
          w_ack_a_n = !r_gnt_b;
          w_ack_b_n = r_gnt_b;
        end else begin
          w_state_n = CAPT;
        end
      end
      CAPT: begin
        if (r_gnt_b) begin
          w_rdata_b_n = bus.mem_rdata;
        end else begin
          w_rdata_a_n = bus.mem_rdata;
        end
        w_ack_a_n = !r_gnt_b;
        w_ack_b_n = r_gnt_b;
        w_state_n = RESP;
      end
      RESP: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
      r_busy      <= 1'b0;
      r_gnt_b     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ack_a     <= w_ack_a_n;
      r_ack_b     <= w_ack_b_n;
      r_mem_en    <= w_mem_en_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_rdata_a   <= w_rdata_a_n;
      r_rdata_b   <= w_rdata_b_n;
      r_busy      <= w_busy_n;
      r_gnt_b     <= w_gnt_b_n;
    end
  end

  assign bus.ack_a     = r_ack_a;
  assign bus.ack_b     = r_ack_b;
  assign bus.rdata_a   = r_rdata_a;
  assign bus.rdata_b   = r_rdata_b;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.gnt_b     = r_gnt_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory issues and acks,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  mem_port_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int unsigned cyc;
    logic        port_b;
    logic        rd;
    logic [31:0] data;
  } ack_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  logic [31:0] ram [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input int unsigned c, input logic we, input logic [13:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic push_ack(input int unsigned c, input logic pb, input logic rd, input logic [31:0] d);
    ack_exp_t e;
    e.cyc = c; e.port_b = pb; e.rd = rd; e.data = d;
    ack_q.push_back(e);
  endtask

  // Monitor: every memory issue and every ack must match the head of its queue.
  always @(negedge clk) begin
    mem_exp_t me;
    ack_exp_t ae;
    chk("ack_exclusive", {63'd0, bus.ack_a & bus.ack_b}, 64'd0);
    if (bus.mem_en) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected", 64'd1, 64'd0);
      end else begin
        me = mem_q.pop_front();
        chk("mem_cycle", 64'(cyc), 64'(me.cyc));
        chk("mem_we", {63'd0, bus.mem_we}, {63'd0, me.we});
        chk("mem_addr", {50'd0, bus.mem_addr}, {50'd0, me.addr});
        if (me.we) chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, me.wdata});
      end
    end
    if (bus.ack_a || bus.ack_b) begin
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", {62'd0, bus.ack_b, bus.ack_a}, 64'd0);
      end else begin
        ae = ack_q.pop_front();
        chk("ack_port", {63'd0, bus.ack_b}, {63'd0, ae.port_b});
        chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
        chk("ack_gnt_b", {63'd0, bus.gnt_b}, {63'd0, ae.port_b});
        if (ae.rd)
          chk("ack_rdata", {32'd0, (ae.port_b ? bus.rdata_b : bus.rdata_a)}, {32'd0, ae.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Drives requests until the wanted number of acks per port is seen, retargeting held ports.
  task automatic serve(input int unsigned need_a, input int unsigned need_b,
                       input logic [13:0] a_next, input logic [13:0] b_next,
                       input int unsigned limit);
    int unsigned na;
    int unsigned nb;
    int unsigned n;
    na = 0; nb = 0; n = 0;
    while ((na < need_a || nb < need_b) && n < limit) begin
      tick();
      n++;
      if (bus.ack_a) begin
        na++;
        if (na >= need_a) bus.req_a = 1'b0; else bus.addr_a = a_next;
      end
      if (bus.ack_b) begin
        nb++;
        if (nb >= need_b) bus.req_b = 1'b0; else bus.addr_b = b_next;
      end
    end
    chk("serve_complete", {63'd0, (na >= need_a && nb >= need_b)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t;
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    rst = 1'b1;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    bus.mem_rdata = '0;
    idle(3);
    rst = 1'b0;

    chk("rst_ack_a", {63'd0, bus.ack_a}, 64'd0);
    chk("rst_ack_b", {63'd0, bus.ack_b}, 64'd0);
    chk("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_gnt_b", {63'd0, bus.gnt_b}, 64'd0);
    chk("rst_mem_addr", {50'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("rst_rdata_a", {32'd0, bus.rdata_a}, 64'd0);
    chk("rst_rdata_b", {32'd0, bus.rdata_b}, 64'd0);
    idle(2);

    // Single A write.
    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 14'h0010; bus.wdata_a = 32'hDEADBEEF;
    push_mem(t + 1, 1'b1, 14'h0010, 32'hDEADBEEF);
    push_ack(t + 2, 1'b0, 1'b0, 32'h0);
    tick();
    chk("busy_in_issue", {63'd0, bus.busy}, 64'd1);
    serve(1, 0, 14'h0010, 14'h0, 10);
    idle(3);
    chk("busy_idle", {63'd0, bus.busy}, 64'd0);

    // A read back; inputs scrambled after grant must not matter.
    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 14'h0010; bus.wdata_a = 32'h0;
    push_mem(t + 1, 1'b0, 14'h0010, 32'h0);
    push_ack(t + 3, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    bus.addr_a = 14'h0055; bus.we_a = 1'b1; bus.wdata_a = 32'hBAD0BAD0;
    serve(1, 0, 14'h0055, 14'h0, 10);
    bus.we_a = 1'b0;
    idle(4);
    chk("rdata_a_hold", {32'd0, bus.rdata_a}, {32'd0, 32'hDEADBEEF});

    // Simultaneous writes after reset.
    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 14'h0020; bus.wdata_a = 32'h11111111;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 14'h0021; bus.wdata_b = 32'h22222222;
`ifdef ARB_B_PRIORITY_EN
    push_mem(t + 1, 1'b1, 14'h0021, 32'h22222222); push_ack(t + 2, 1'b1, 1'b0, 32'h0);
    push_mem(t + 4, 1'b1, 14'h0020, 32'h11111111); push_ack(t + 5, 1'b0, 1'b0, 32'h0);
`else
    push_mem(t + 1, 1'b1, 14'h0020, 32'h11111111); push_ack(t + 2, 1'b0, 1'b0, 32'h0);
    push_mem(t + 4, 1'b1, 14'h0021, 32'h22222222); push_ack(t + 5, 1'b1, 1'b0, 32'h0);
`endif
    serve(1, 1, 14'h0020, 14'h0021, 20);
    idle(3);

    // Second tie: B first in both builds.
    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 14'h0022; bus.wdata_a = 32'h33333333;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 14'h0023; bus.wdata_b = 32'h44444444;
    push_mem(t + 1, 1'b1, 14'h0023, 32'h44444444); push_ack(t + 2, 1'b1, 1'b0, 32'h0);
    push_mem(t + 4, 1'b1, 14'h0022, 32'h33333333); push_ack(t + 5, 1'b0, 1'b0, 32'h0);
    serve(1, 1, 14'h0022, 14'h0023, 20);
    idle(3);

    // A held high while B reads back-to-back.
    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 14'h0022;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 14'h0021;
`ifdef ARB_B_PRIORITY_EN
    push_mem(t + 1,  1'b0, 14'h0021, 32'h0); push_ack(t + 3,  1'b1, 1'b1, 32'h22222222);
    push_mem(t + 5,  1'b0, 14'h0023, 32'h0); push_ack(t + 7,  1'b1, 1'b1, 32'h44444444);
    push_mem(t + 9,  1'b0, 14'h0022, 32'h0); push_ack(t + 11, 1'b0, 1'b1, 32'h33333333);
    push_mem(t + 13, 1'b0, 14'h0022, 32'h0); push_ack(t + 15, 1'b0, 1'b1, 32'h33333333);
`else
    push_mem(t + 1,  1'b0, 14'h0022, 32'h0); push_ack(t + 3,  1'b0, 1'b1, 32'h33333333);
    push_mem(t + 5,  1'b0, 14'h0021, 32'h0); push_ack(t + 7,  1'b1, 1'b1, 32'h22222222);
    push_mem(t + 9,  1'b0, 14'h0022, 32'h0); push_ack(t + 11, 1'b0, 1'b1, 32'h33333333);
    push_mem(t + 13, 1'b0, 14'h0023, 32'h0); push_ack(t + 15, 1'b1, 1'b1, 32'h44444444);
`endif
    serve(2, 2, 14'h0022, 14'h0023, 40);
    idle(3);

    // Reset during CAPT of a B read: no ack, everything back to zero.
    t = cyc;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 14'h0021;
    push_mem(t + 1, 1'b0, 14'h0021, 32'h0);
    idle(2);
    rst = 1'b1;
    bus.req_b = 1'b0;
    tick();
    chk("abort_ack_b", {63'd0, bus.ack_b}, 64'd0);
    chk("abort_mem_en", {63'd0, bus.mem_en}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_gnt_b", {63'd0, bus.gnt_b}, 64'd0);
    chk("abort_mem_addr", {50'd0, bus.mem_addr}, 64'd0);
    chk("abort_rdata_b", {32'd0, bus.rdata_b}, 64'd0);
    rst = 1'b0;
    idle(3);

    t = cyc;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 14'h0020;
    push_mem(t + 1, 1'b0, 14'h0020, 32'h0);
    push_ack(t + 3, 1'b0, 1'b1, 32'h11111111);
    serve(1, 0, 14'h0020, 14'h0, 10);
    idle(4);
    chk("final_gnt_b", {63'd0, bus.gnt_b}, 64'd0);
    chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
